scan_chain_receiver: RTL

Downstream consumer of the pseudo-SPI scan output (SCLK1/SCLK2/LAT/SPI_SO) driven by the CPU/ALU/SRAM controller top. It models and implements the analog-side configuration register as a synthesizable block on the system clock. The block oversamples the two-phase scan clocks and reassembles the serial stream into a parallel configuration word. The word is committed on LAT, and framing, overlap and parity errors are reported.

---
 rtl/scan_chain_receiver.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/scan_chain_receiver.sv
// Scan chain receiver: oversamples SCLK1/SCLK2/LAT/SPI_SO, rebuilds the
// serial frame and commits it to CFG_DATA on LAT, flagging framing errors.
// Ports: CLK, RST_N (async low), SCLK1/SCLK2 two-phase scan clocks, LAT
// commit strobe, SPI_SO data, CLR_ERR clears sticky flags; outputs CFG_DATA,
// CFG_VALID pulse, BIT_CNT, BUSY, ERR_SHORT/LONG/OVLP/PARITY.
// Option: define SCAN_PARITY_EN to append an even-parity bit to each frame.
module scan_chain_receiver #(
  parameter int CHAIN_LEN   = 64,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 7
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 SCLK1,
  input  logic                 SCLK2,
  input  logic                 LAT,
  input  logic                 SPI_SO,
  input  logic                 CLR_ERR,
  output logic [CHAIN_LEN-1:0] CFG_DATA,
  output logic                 CFG_VALID,
  output logic [CNT_WIDTH-1:0] BIT_CNT,
  output logic                 BUSY,
  output logic                 ERR_SHORT,
  output logic                 ERR_LONG,
  output logic                 ERR_OVLP,
  output logic                 ERR_PARITY
);

`ifdef SCAN_PARITY_EN
  localparam int EXP = CHAIN_LEN + 1;
`else
  localparam int EXP = CHAIN_LEN;
`endif
  localparam logic [CNT_WIDTH-1:0] EXP_C = CNT_WIDTH'(EXP);
  localparam int MS = SYNC_STAGES - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FULL
  } state_t;

  logic [SYNC_STAGES-1:0] r_s1_sync, r_s2_sync;
  logic [SYNC_STAGES-1:0] r_lat_sync, r_so_sync;
  logic r_s1_hist, r_s2_hist, r_lat_hist;

  state_t r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [EXP-1:0] r_sr, w_sr_nxt;
  logic [CHAIN_LEN-1:0] r_cfg, w_cfg_nxt;
  logic r_mbit, w_mbit_nxt;
  logic r_valid, r_busy;
  logic r_err_short, r_err_long, r_err_ovlp;
  logic w_s1_rise, w_s2_rise, w_lat_rise;
  logic w_commit, w_ev_short, w_ev_long, w_ev_ovlp;
  logic w_par_ok;
  logic [CHAIN_LEN-1:0] w_data;

  assign w_s1_rise  = r_s1_sync[MS] & ~r_s1_hist;
  assign w_s2_rise  = r_s2_sync[MS] & ~r_s2_hist;
  assign w_lat_rise = r_lat_sync[MS] & ~r_lat_hist;

`ifdef SCAN_PARITY_EN
  logic r_err_par, w_ev_par;
  // Even parity: data bits plus the trailing parity bit XOR to zero.
  assign w_par_ok   = ~^r_sr;
  assign w_data     = r_sr[CHAIN_LEN:1];
  assign ERR_PARITY = r_err_par;
`else
  assign w_par_ok   = 1'b1;
  assign w_data     = r_sr[CHAIN_LEN-1:0];
  assign ERR_PARITY = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1_sync  <= '0;
      r_s2_sync  <= '0;
      r_lat_sync <= '0;
      r_so_sync  <= '0;
      r_s1_hist  <= 1'b0;
      r_s2_hist  <= 1'b0;
      r_lat_hist <= 1'b0;
    end else begin
      r_s1_sync  <= {r_s1_sync[MS-1:0], SCLK1};
      r_s2_sync  <= {r_s2_sync[MS-1:0], SCLK2};
      r_lat_sync <= {r_lat_sync[MS-1:0], LAT};
      r_so_sync  <= {r_so_sync[MS-1:0], SPI_SO};
      r_s1_hist  <= r_s1_sync[MS];
      r_s2_hist  <= r_s2_sync[MS];
      r_lat_hist <= r_lat_sync[MS];
    end
  end

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_sr_nxt   = r_sr;
    w_mbit_nxt = r_mbit;
    w_cfg_nxt  = r_cfg;
    w_commit   = 1'b0;
    w_ev_short = 1'b0;
    w_ev_long  = 1'b0;
    w_ev_ovlp  = 1'b0;
`ifdef SCAN_PARITY_EN
    w_ev_par   = 1'b0;
`endif
    if (w_s1_rise && w_s2_rise) begin
      w_ev_ovlp = 1'b1;
    end else if (w_s1_rise) begin
      w_mbit_nxt = r_so_sync[MS];
    end
    // LAT beats a coincident shift; decision uses pre-shift count.
    if (w_lat_rise) begin
      w_cnt_nxt = '0;
      if (r_state == ST_FULL && w_par_ok) begin
        w_commit  = 1'b1;
        w_cfg_nxt = w_data;
      end
`ifdef SCAN_PARITY_EN
      else if (r_state == ST_FULL) begin
        w_ev_par = 1'b1;
      end
`endif
      else begin
        w_ev_short = 1'b1;
      end
    end else if (w_s2_rise && !w_s1_rise) begin
      if (r_state == ST_FULL) begin
        w_ev_long = 1'b1;
      end else begin
        w_sr_nxt  = {r_sr[EXP-2:0], r_mbit};
        w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
      end
    end
    if (w_cnt_nxt == '0) begin
      w_state_nxt = ST_IDLE;
    end else if (w_cnt_nxt == EXP_C) begin
      w_state_nxt = ST_FULL;
    end else begin
      w_state_nxt = ST_SHIFT;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_mbit      <= 1'b0;
      r_cfg       <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_err_ovlp  <= 1'b0;
`ifdef SCAN_PARITY_EN
      r_err_par   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sr        <= w_sr_nxt;
      r_mbit      <= w_mbit_nxt;
      r_cfg       <= w_cfg_nxt;
      r_valid     <= w_commit;
      r_busy      <= (w_cnt_nxt != '0);
      r_err_short <= w_ev_short | (r_err_short & ~CLR_ERR);
      r_err_long  <= w_ev_long | (r_err_long & ~CLR_ERR);
      r_err_ovlp  <= w_ev_ovlp | (r_err_ovlp & ~CLR_ERR);
`ifdef SCAN_PARITY_EN
      r_err_par   <= w_ev_par | (r_err_par & ~CLR_ERR);
`endif
    end
  end

  assign CFG_DATA  = r_cfg;
  assign CFG_VALID = r_valid;
  assign BIT_CNT   = r_cnt;
  assign BUSY      = r_busy;
  assign ERR_SHORT = r_err_short;
  assign ERR_LONG  = r_err_long;
  assign ERR_OVLP  = r_err_ovlp;

endmodule
